// File: rtl/alu_muldiv_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_decoder
// Purpose  : EX-stage ALU control decode with HI/LO pair and an iterative
//            radix-2 mult/div engine; engine enabled by ALUDEC_MULDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_decoder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic             illegal,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_comb begin
        alucontrol = 4'b0010;
        illegal    = 1'b0;
        case (aluop)
            2'b00: alucontrol = 4'b0010;
            2'b01: alucontrol = 4'b0110;
            2'b11: illegal    = 1'b1;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alucontrol = 4'b0010;
                    6'b100010, 6'b100011: alucontrol = 4'b0110;
                    6'b100100:            alucontrol = 4'b0000;
                    6'b100101:            alucontrol = 4'b0001;
                    6'b100110:            alucontrol = 4'b0011;
                    6'b100111:            alucontrol = 4'b1100;
                    6'b101010:            alucontrol = 4'b0111;
                    6'b101011:            alucontrol = 4'b1111;
`ifdef ALUDEC_MULDIV_EN
                    6'b010000:            alucontrol = 4'b1000;
                    6'b010010:            alucontrol = 4'b1001;
                    6'b010001, 6'b010011,
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: alucontrol = 4'b0010;
`endif
                    default: begin
                        alucontrol = 4'b0000;
                        illegal    = 1'b1;
                    end
                endcase
            end
        endcase
    end

`ifdef ALUDEC_MULDIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_busy;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_hilo_class;
    logic               w_accept;
    logic               w_is_muldiv;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH-1:0]   w_ddiff;
    logic               w_dge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remfix;

    assign w_hilo_class = (aluop == 2'b10) &&
                          (funct inside {6'b010000, 6'b010001, 6'b010010, 6'b010011,
                                         6'b011000, 6'b011001, 6'b011010, 6'b011011});
    assign w_accept     = valid & w_hilo_class & (r_state == S_IDLE);
    assign w_is_muldiv  = (funct[5:2] == 4'b0110);
    // Odd functs (multu/divu) are the unsigned forms.
    assign w_a_neg      = ~funct[0] & srca[WIDTH-1];
    assign w_b_neg      = ~funct[0] & srcb[WIDTH-1];
    assign w_abs_a      = w_a_neg ? -srca : srca;
    assign w_abs_b      = w_b_neg ? -srcb : srcb;
    assign w_last       = (r_count == CW'(WIDTH - 1));

    // Multiply: accumulate into r_rem, shift the product down through r_q.
    assign w_msum   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_m} : '0);
    // Divide: restoring step, quotient bits shift into r_q from the bottom.
    assign w_dshift = {r_rem, r_q[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_m});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_m;

    assign w_prod   = (r_neg_a ^ r_neg_b) ? -{r_rem, r_q} : {r_rem, r_q};
    assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
    assign w_remfix = r_neg_a ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_muldiv) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_m      <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_busy   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_muldiv) begin
                            r_count  <= '0;
                            r_rem    <= '0;
                            r_is_div <= funct[1];
                            r_neg_a  <= w_a_neg;
                            r_neg_b  <= w_b_neg;
                            r_m      <= funct[1] ? w_abs_b : w_abs_a;
                            r_q      <= funct[1] ? w_abs_a : w_abs_b;
                        end else if (funct == 6'b010001) begin
                            r_hi <= srca;
                        end else if (funct == 6'b010011) begin
                            r_lo <= srca;
                        end
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_is_div) begin
                        r_rem <= w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_dge};
                    end else begin
                        r_rem <= w_msum[WIDTH:1];
                        r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_remfix;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign stall = valid & w_hilo_class & (r_state != S_IDLE);
    assign hi    = r_hi;
    assign lo    = r_lo;
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset_n, valid, srca, srcb};

    assign busy  = 1'b0;
    assign stall = 1'b0;
    assign hi    = '0;
    assign lo    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_decoder
// Purpose  : Self-checking bench: decode sweep plus randomized mult/div
//            against an arithmetic reference model (ALUDEC_MULDIV_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_decoder;
    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ALUDEC_MULDIV_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             valid = 1'b0;
    logic [1:0]       aluop = 2'b00;
    logic [5:0]       funct = 6'd0;
    logic [WIDTH-1:0] srca = '0;
    logic [WIDTH-1:0] srcb = '0;
    logic [3:0]       alucontrol;
    logic             illegal;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv_decoder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .aluop(aluop), .funct(funct),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .illegal(illegal),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_hilo(input logic [5:0] f);
        return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
    endfunction

    // Returns {illegal, alucontrol} straight from the decode table.
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        logic [4:0] r;
        r = 5'b1_0000;
        if (op == 2'b00)      r = 5'b0_0010;
        else if (op == 2'b01) r = 5'b0_0110;
        else if (op == 2'b11) r = 5'b1_0010;
        else if (is_hilo(f) && !EN) r = 5'b1_0000;
        else begin
            case (f)
                6'h20, 6'h21: r = 5'b0_0010;
                6'h22, 6'h23: r = 5'b0_0110;
                6'h24: r = 5'b0_0000;
                6'h25: r = 5'b0_0001;
                6'h26: r = 5'b0_0011;
                6'h27: r = 5'b0_1100;
                6'h2a: r = 5'b0_0111;
                6'h2b: r = 5'b0_1111;
                6'h10: r = 5'b0_1000;
                6'h12: r = 5'b0_1001;
                6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: r = 5'b0_0010;
                default: r = 5'b1_0000;
            endcase
        end
        return r;
    endfunction

    // Returns {hi, lo} for mult/multu/div/divu using native wide arithmetic.
    function automatic logic [2*WIDTH-1:0] ref_muldiv(input logic [5:0] f,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] sa, sb, sq, sr;
        logic [2*WIDTH-1:0]        ua, ub, res;
        logic [WIDTH-1:0]          q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {{WIDTH{1'b0}}, a};
        ub = {{WIDTH{1'b0}}, b};
        res = '0;
        case (f)
            6'h18: res = sa * sb;
            6'h19: res = ua * ub;
            6'h1a: begin
                if (b == '0) begin
                    q = a[WIDTH-1] ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
                    r = a;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q  = sq[WIDTH-1:0];
                    r  = sr[WIDTH-1:0];
                end
                res = {r, q};
            end
            default: begin
                if (b == '0) begin
                    q = '1;
                    r = a;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                res = {r, q};
            end
        endcase
        return res;
    endfunction

    // Entered and left at posedge+1.
    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] exp;
        int cyc;
        exp   = ref_muldiv(f, a, b);
        valid = 1'b1; aluop = 2'b10; funct = f; srca = a; srcb = b;
        #1 check({tag, " stall_idle"}, 64'(stall), 64'd0);
        @(posedge clk); #1;
        valid = 1'b0; srca = $urandom; srcb = $urandom;
        cyc = 0;
        while (busy && cyc < 4 * WIDTH) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'(WIDTH + 1));
        check({tag, " hi"}, 64'(hi), 64'(exp[2*WIDTH-1:WIDTH]));
        check({tag, " lo"}, 64'(lo), 64'(exp[WIDTH-1:0]));
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return MINV;
            3:       return WIDTH'($urandom_range(1, 20));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]         d;
        logic [2*WIDTH-1:0] exp;
        int                 cyc;
        logic [5:0]         fsel [4] = '{6'h18, 6'h19, 6'h1a, 6'h1b};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Decode sweep; valid kept low in the full build so nothing starts.
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                aluop = 2'(op); funct = 6'(f);
                valid = EN ? 1'b0 : 1'($urandom);
                srca  = $urandom; srcb = $urandom;
                #1;
                d = ref_decode(2'(op), 6'(f));
                check($sformatf("dec op%0d f%02h ctl", op, f), 64'(alucontrol), 64'(d[3:0]));
                check($sformatf("dec op%0d f%02h ill", op, f), 64'(illegal), 64'(d[4]));
                check($sformatf("dec op%0d f%02h stall", op, f), 64'(stall), 64'd0);
            end
        end
        @(posedge clk); #1;
        check("sweep busy", 64'(busy), 64'd0);
        valid = 1'b0;

`ifdef ALUDEC_MULDIV_EN
        run_op("mult -3*7", 6'h18, -32'sd3, 32'd7);
        check("mult -3*7 hi const", 64'(hi), 64'hFFFFFFFF);
        check("mult -3*7 lo const", 64'(lo), 64'hFFFFFFEB);
        run_op("multu max*max", 6'h19, '1, '1);
        run_op("div -7/2", 6'h1a, -32'sd7, 32'd2);
        run_op("divu 7/0", 6'h1b, 32'd7, '0);
        run_op("div min/-1", 6'h1a, MINV, '1);
        check("div min/-1 lo const", 64'(lo), 64'h80000000);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("rand%0d", i), fsel[$urandom_range(0, 3)],
                   pick_operand(), pick_operand());

        // mult then mflo: mflo stalls until the engine is back in IDLE.
        exp   = ref_muldiv(6'h18, 32'h12345, 32'h6789);
        valid = 1'b1; aluop = 2'b10; funct = 6'h18; srca = 32'h12345; srcb = 32'h6789;
        @(posedge clk); #1;
        funct = 6'h12;
        #1;
        cyc = 0;
        while (stall && cyc < 4 * WIDTH) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("mflo stall_cycles", 64'(cyc), 64'(WIDTH + 1));
        check("mflo ctl", 64'(alucontrol), 64'b1001);
        check("mflo lo", 64'(lo), 64'(exp[WIDTH-1:0]));
        @(posedge clk); #1;
        valid = 1'b0;

        // Independent ALU op during RUN proceeds without stalling.
        exp   = ref_muldiv(6'h1b, 32'd1000, 32'd7);
        valid = 1'b1; aluop = 2'b10; funct = 6'h1b; srca = 32'd1000; srcb = 32'd7;
        @(posedge clk); #1;
        funct = 6'h24;
        #1;
        check("and in RUN stall", 64'(stall), 64'd0);
        check("and in RUN ctl", 64'(alucontrol), 64'b0000);
        check("and in RUN busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 4 * WIDTH) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("divu parallel hi", 64'(hi), 64'(exp[2*WIDTH-1:WIDTH]));
        check("divu parallel lo", 64'(lo), 64'(exp[WIDTH-1:0]));

        // Reset in RUN cycle 10 aborts and clears HI/LO.
        valid = 1'b1; aluop = 2'b10; funct = 6'h18; srca = 32'd55; srcb = 32'd77;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        reset_n = 1'b1;

        valid = 1'b1; aluop = 2'b10; funct = 6'h11; srca = 32'h1234;
        #1 check("mthi stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi busy", 64'(busy), 64'd0);
        funct = 6'h13; srca = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("mtlo lo", 64'(lo), 64'hCAFEF00D);
        check("mtlo hi kept", 64'(hi), 64'h1234);
        valid = 1'b0;
`else
        // Without the engine, HI/LO-class instructions must have no effect.
        valid = 1'b1; aluop = 2'b10; funct = 6'h18; srca = 32'd9; srcb = 32'd9;
        for (int i = 0; i < 8; i++) begin
            funct = 6'h10 + 6'($urandom_range(0, 3)) + (i[0] ? 6'h08 : 6'h00);
            #1;
            check("noen ill", 64'(illegal), 64'd1);
            check("noen stall", 64'(stall), 64'd0);
            @(posedge clk); #1;
            check("noen busy", 64'(busy), 64'd0);
            check("noen hi", 64'(hi), 64'd0);
            check("noen lo", 64'(lo), 64'd0);
        end
        valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
